// File: rtl/order_sequencer.sv
// order_sequencer: re-orders 2nd-level parser results into grant order.
// Grant indices are queued; the head parser's word is popped when ready.
module order_sequencer #(
    parameter int NUM_PARSER  = 6,
    parameter int DATA_W      = 144,
    parameter int ORDER_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         grant_valid,
    input  logic [NUM_PARSER-1:0]        grant,
    input  logic [NUM_PARSER-1:0]        par_valid,
    input  logic [NUM_PARSER*DATA_W-1:0] par_data,
    output logic [NUM_PARSER-1:0]        par_rdreq,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic                         order_stop,
    output logic                         order_empty,
    output logic                         err,
    output logic [15:0]                  out_count
);

    localparam int IDX_W = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1;
    localparam int PTR_W = $clog2(ORDER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]      mem [ORDER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      head;
    logic [NUM_PARSER-1:0] head_oh;
    logic [DATA_W-1:0]     head_data;
    logic                  onehot;
    logic                  full;
    logic                  nonempty;
    logic                  push;
    logic                  load;
    logic                  bad_grant;

    assign onehot   = (grant != '0) &&
                      ((grant & (grant - NUM_PARSER'(1))) == '0);
    assign full     = (occ == CNT_W'(ORDER_DEPTH));
    assign nonempty = (occ != '0);
    assign push     = grant_valid && onehot && !full;
    assign bad_grant = grant_valid && (!onehot || full);
    assign head     = mem[rd_ptr];

    // Encode the one-hot grant into a binary parser index.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PARSER; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
    end

    // Decode the head index and select that parser's result word.
    always_comb begin
        head_oh   = '0;
        head_data = '0;
        for (int i = 0; i < NUM_PARSER; i++) begin
            head_oh[i] = (head == IDX_W'(i));
            if (head_oh[i]) head_data = par_data[i*DATA_W +: DATA_W];
        end
    end

    // Load the output register when the head result is present and
    // the register is free or being drained this cycle.
    assign load = !rst && nonempty && ((head_oh & par_valid) != '0) &&
                  (!out_valid || out_ready);
    assign par_rdreq   = load ? head_oh : '0;
    assign order_stop  = (occ >= CNT_W'(ORDER_DEPTH - 2));
    assign order_empty = !nonempty;

    // Order FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= grant_idx;
    end

    // Order FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !load)      occ <= occ + CNT_W'(1);
            else if (load && !push) occ <= occ - CNT_W'(1);
        end
    end

    // Single output register holding the in-order result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= head_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count accepted results and latch protocol errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_count <= out_count + 16'd1;
            if (bad_grant) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_order_sequencer.sv
// tb_order_sequencer: directed checks of grant-order re-sequencing.
// Inputs change 1ns after the rising edge; checks follow at +1ns more.
module tb_order_sequencer;

    localparam int NP = 6;
    localparam int DW = 144;
    localparam int OD = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             grant_valid;
    logic [NP-1:0]    grant;
    logic [NP-1:0]    par_valid;
    logic [NP*DW-1:0] par_data;
    logic [NP-1:0]    par_rdreq;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic             order_stop;
    logic             order_empty;
    logic             err;
    logic [15:0]      out_count;

    int vectors = 0;
    int errs    = 0;

    order_sequencer #(.NUM_PARSER(NP), .DATA_W(DW), .ORDER_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .grant_valid(grant_valid), .grant(grant),
        .par_valid(par_valid), .par_data(par_data), .par_rdreq(par_rdreq),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .order_stop(order_stop), .order_empty(order_empty), .err(err),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pw(input int i);
        logic [DW-1:0] w;
        w = {16'hC0DE, 120'(i * 7 + 1), 8'(i)};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx);
        grant_valid = 1'b1;
        grant = NP'(1) << idx;
        tick();
        grant_valid = 1'b0;
        grant = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_od"}, out_data, 0);
        chk({tag, "_rd"}, par_rdreq, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_emp"}, order_empty, 1);
        chk({tag, "_stop"}, order_stop, 0);
        chk({tag, "_cnt"}, out_count, 0);
        chk({tag, "_occ"}, dut.occ, 0);
    endtask

    initial begin
        rst = 1'b1;
        grant_valid = 1'b0;
        grant = '0;
        par_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NP; i++) par_data[i*DW +: DW] = pw(i);
        tick();
        tick();
        #1;
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Grants 0,1,2; results arrive 2,1,0; emitted 0,1,2.
        push(0);
        push(1);
        push(2);
        chk("a_occ", dut.occ, 3);
        chk("a_emp", order_empty, 0);
        par_valid = 6'b000100;
        #1 chk("a_rd_p2", par_rdreq, 0);
        tick();
        par_valid = 6'b000110;
        #1 chk("a_rd_p1", par_rdreq, 0);
        chk("a_ov0", out_valid, 0);
        tick();
        par_valid = 6'b000111;
        #1 chk("a_rd0", par_rdreq, 6'b000001);
        tick();
        chk("a_ov1", out_valid, 1);
        chk("a_d0", out_data, pw(0));
        par_valid = 6'b000110;
        #1 chk("a_rd1", par_rdreq, 6'b000010);
        tick();
        chk("a_d1", out_data, pw(1));
        par_valid = 6'b000100;
        #1 chk("a_rd2", par_rdreq, 6'b000100);
        tick();
        chk("a_d2", out_data, pw(2));
        chk("a_ov2", out_valid, 1);
        par_valid = '0;
        #1 chk("a_rd_none", par_rdreq, 0);
        tick();
        chk("a_ov_clr", out_valid, 0);
        chk("a_cnt", out_count, 3);
        chk("a_emp2", order_empty, 1);

        // Backpressure: output held 5 cycles, then next word.
        push(0);
        push(1);
        out_ready = 1'b0;
        par_valid = 6'b000011;
        #1 chk("c_rd0", par_rdreq, 6'b000001);
        tick();
        par_valid = 6'b000010;
        chk("c_ov", out_valid, 1);
        chk("c_d0", out_data, pw(0));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("c_hold_rd%0d", k), par_rdreq, 0);
            chk($sformatf("c_hold_ov%0d", k), out_valid, 1);
            chk($sformatf("c_hold_d%0d", k), out_data, pw(0));
            tick();
        end
        out_ready = 1'b1;
        #1 chk("c_rd1", par_rdreq, 6'b000010);
        tick();
        chk("c_d1", out_data, pw(1));
        chk("c_ov1", out_valid, 1);
        par_valid = '0;
        tick();
        chk("c_ov_clr", out_valid, 0);
        chk("c_cnt", out_count, 5);

        // Simultaneous push and pop at occupancy 3.
        push(3);
        push(4);
        push(5);
        chk("d_occ3", dut.occ, 3);
        par_valid = 6'b111001;
        grant_valid = 1'b1;
        grant = 6'b000001;
        #1 chk("d_rd3", par_rdreq, 6'b001000);
        tick();
        grant_valid = 1'b0;
        grant = '0;
        chk("d_occ_same", dut.occ, 3);
        chk("d_d3", out_data, pw(3));
        par_valid = 6'b110001;
        tick();
        chk("d_d4", out_data, pw(4));
        chk("d_occ2", dut.occ, 2);
        par_valid = 6'b100001;
        tick();
        chk("d_d5", out_data, pw(5));
        par_valid = 6'b000001;
        tick();
        chk("d_d0", out_data, pw(0));
        chk("d_occ0", dut.occ, 0);
        par_valid = '0;
        tick();
        chk("d_ov_clr", out_valid, 0);
        chk("d_cnt", out_count, 9);

        // Fill to full: stop at 14, accept 16, 17th is an error.
        for (int i = 0; i < 13; i++) push(i % NP);
        chk("b_occ13", dut.occ, 13);
        chk("b_stop13", order_stop, 0);
        push(1);
        chk("b_occ14", dut.occ, 14);
        chk("b_stop14", order_stop, 1);
        push(2);
        push(3);
        chk("b_occ16", dut.occ, 16);
        chk("b_err16", err, 0);
        push(4);
        chk("b_err17", err, 1);
        chk("b_occ17", dut.occ, 16);
        chk("b_stop17", order_stop, 1);

        rst = 1'b1;
        #1 check_reset("rst2");
        tick();
        rst = 1'b0;
        tick();

        // Non-one-hot grant is rejected and flagged.
        grant_valid = 1'b1;
        grant = 6'b000011;
        tick();
        grant_valid = 1'b0;
        grant = '0;
        chk("e_err", err, 1);
        chk("e_occ", dut.occ, 0);
        tick();
        chk("e_err_sticky", err, 1);

        // Reset mid-operation with occupancy 5 and a held word.
        for (int i = 0; i < 6; i++) push(i);
        out_ready = 1'b0;
        par_valid = 6'b000001;
        tick();
        par_valid = 6'b111110;
        chk("f_ov", out_valid, 1);
        chk("f_occ5", dut.occ, 5);
        out_ready = 1'b1;
        #1 chk("f_rd_pre", par_rdreq, 6'b000010);
        rst = 1'b1;
        #1 check_reset("f_rst");
        tick();
        rst = 1'b0;
        par_valid = '0;
        tick();
        chk("f_emp_after", order_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
